keypad_scan: RTL and testbench
==============================

# keypad_scan

4x4 matrix keypad scanner that produces the 32-bit hex word shown by the 8-digit seven-segment display driver. It drives the keypad columns one at a time, debounces row returns, decodes the pressed key to a hex nibble, and shifts that nibble into a 32-bit entry register. The display side reads the register directly. The block sits between the board keypad pins and the display `d` input, and is the input-side counterpart of the display multiplexer.

## Interface
Parameters:
- `SCAN_DIV`, default 16'd50000: clk cycles per scan tick.
- `DEBOUNCE`, default 4'd10: number of consecutive stable ticks needed to accept a press, and also to accept a release.
- `REPEAT_TICKS`, default 10'd500: ticks between auto-repeat events. Used only when `KEYPAD_REPEAT_EN` is defined.

Ports:
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `row` input 4: keypad rows, active-low, pulled up externally.
- `clr` input 1: synchronous clear of `d`, active-high.
- `col` output 4: keypad column drive, active-low, exactly one bit low at all times.
- `d` output 32: entry register, newest nibble in `d[3:0]`.
- `key_code` output 4: code of the last accepted key.
- `key_valid` output 1: one-clk pulse per accepted key event.

## Operation
- Input sync: `row` passes through a 2-flop synchronizer (`row_s`). All decisions use `row_s`.
- Tick: a counter runs 0..SCAN_DIV-1. `tick` is high for one clk cycle when the counter equals SCAN_DIV-1, then the counter wraps to 0.
- Column drive: `col = ~(4'b0001 << cidx)`.
- Key code: `code = {ridx[1:0], cidx[1:0]}`, i.e. row*4 + col. If several rows are low, the lowest row index wins.
- State machine, evaluated only on `tick`:
  - SCAN:
    - `row_s == 4'hF` → `cidx` increments, wrapping 3→0.
    - Otherwise → latch `ridx` and `row_s` as `rsave`, clear `dcnt`, go to DEBOUNCE. `cidx` is held.
  - DEBOUNCE:
    - `row_s == rsave` → `dcnt++`. When `dcnt` reaches DEBOUNCE-1 → accept the key and go to PRESSED.
    - Otherwise → go to SCAN and increment `cidx`.
  - PRESSED:
    - `row_s == 4'hF` → `rcnt++`. When `rcnt` reaches DEBOUNCE-1 → go to SCAN and increment `cidx`.
    - Otherwise → clear `rcnt`.
- Accept: on the same clk edge,
  - `key_valid <= 1`,
  - `key_code <= code`,
  - `d <= {d[27:0], code}`.
- Oldest nibble: `d[31:28]` is discarded on each shift.
- `clr`: sets `d` to 0 on the next edge. If `clr` and an accept coincide, `clr` wins: `d = 0`, but `key_valid` and `key_code` still update.
- Reset values:
  - state SCAN, `cidx = 0`, `col = 4'b1110`,
  - `d = 32'h0`, `key_code = 4'h0`, `key_valid = 0`,
  - all counters 0, synchronizer flops 4'hF.

## Timing
- `key_valid` is high for exactly one clk cycle, the cycle after the tick edge on which the accepting sample is taken.
- `d` and `key_code` change on that same edge.
- Press-to-`key_valid` latency: at most 2 clk (sync) + 4 ticks (scan) + DEBOUNCE ticks + 1 clk.
- A release shorter than DEBOUNCE ticks does not end PRESSED, so the key is not re-accepted.
- `col` changes only on tick edges. It never changes in DEBOUNCE or PRESSED.
- Reset asserted mid-operation: every output returns to its reset value immediately, and scanning restarts at column 0.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
- Defined: PRESSED keeps a counter `pcnt` of ticks while `row_s == rsave`.
  - When `pcnt` reaches REPEAT_TICKS-1 → perform an accept with the same code and clear `pcnt`.
  - `pcnt` is cleared on entry to PRESSED and whenever `row_s != rsave`.
- Not defined: no repeat logic. Exactly one accept per press.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=3, REPEAT_TICKS=8.
- Reset → `col = 4'b1110`, `d = 0`, `key_valid = 0`. With no key pressed, `col` steps 1110→1101→1011→0111→1110, one step every 4 clk.
- Hold row1/col2 (`row = 4'b1101` while col2 is low) for 10 ticks, then release → exactly one `key_valid`, `key_code = 4'h6`, `d = 32'h00000006`. Then press row3/col3 → `d = 32'h0000006F`.
- Row contact bounces (stable for 1 tick, then high) → state returns to SCAN, no `key_valid`, `d` unchanged.
- Nine presses of codes 1..9 → `d = 32'h23456789`. Asserting `clr` on the cycle of the 9th accept → `d = 0`, `key_code = 9`.
- Assert reset while in PRESSED → `d = 0` and `col = 4'b1110` immediately. Keep the key held after reset releases → it is re-accepted after the debounce time.
- With `KEYPAD_REPEAT_EN` defined: hold key 0xA for 30 ticks after accept → 1 initial pulse plus 3 repeat pulses, `d = 32'h0000AAAA`. Without the macro → 1 pulse only, `d = 32'h0000000A`.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-hot-low column drive, debounced row sampling, hex-nibble
// entry register. Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
`timescale 1ns/1ps

module keypad_scan #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [3:0]  DEBOUNCE     = 4'd10,
  parameter logic [9:0]  REPEAT_TICKS = 10'd500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [31:0] d,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  state_e      state_q;
  logic [3:0]  row_s1_q, row_s_q;
  logic [15:0] div_q;
  logic [1:0]  cidx_q, ridx_q, ridx_new;
  logic [3:0]  rsave_q;
  logic [3:0]  dcnt_q, rcnt_q;
  logic [31:0] d_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        tick, accept;
  logic [3:0]  code;
`ifdef KEYPAD_REPEAT_EN
  logic [9:0]  pcnt_q;
`endif

  assign tick      = (div_q == SCAN_DIV - 16'd1);
  assign code      = {ridx_q, cidx_q};
  assign col       = ~(4'b0001 << cidx_q);
  assign d         = d_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

  // Lowest active (low) row index wins when several rows are pulled down.
  always_comb begin
    ridx_new = 2'd3;
    if (!row_s_q[0])      ridx_new = 2'd0;
    else if (!row_s_q[1]) ridx_new = 2'd1;
    else if (!row_s_q[2]) ridx_new = 2'd2;
  end

  always_comb begin
    accept = 1'b0;
    if (tick) begin
      case (state_q)
        StDebounce: accept = (row_s_q == rsave_q) && (dcnt_q == DEBOUNCE - 4'd1);
`ifdef KEYPAD_REPEAT_EN
        StPressed:  accept = (row_s_q == rsave_q) && (pcnt_q == REPEAT_TICKS - 10'd1);
`endif
        default:    accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StScan;
      row_s1_q    <= 4'hF;
      row_s_q     <= 4'hF;
      div_q       <= '0;
      cidx_q      <= '0;
      ridx_q      <= '0;
      rsave_q     <= 4'hF;
      dcnt_q      <= '0;
      rcnt_q      <= '0;
      d_q         <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      pcnt_q      <= '0;
`endif
    end else begin
      row_s1_q    <= row;
      row_s_q     <= row_s1_q;
      key_valid_q <= 1'b0;
      div_q       <= tick ? 16'd0 : div_q + 16'd1;

      if (tick) begin
        case (state_q)
          StScan: begin
            if (row_s_q == 4'hF) begin
              cidx_q <= cidx_q + 2'd1;
            end else begin
              ridx_q  <= ridx_new;
              rsave_q <= row_s_q;
              dcnt_q  <= '0;
              state_q <= StDebounce;
            end
          end
          StDebounce: begin
            if (row_s_q == rsave_q) begin
              dcnt_q <= dcnt_q + 4'd1;
              if (accept) begin
                state_q <= StPressed;
                rcnt_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
                pcnt_q  <= '0;
`endif
              end
            end else begin
              state_q <= StScan;
              cidx_q  <= cidx_q + 2'd1;
            end
          end
          StPressed: begin
            // Release must be seen on DEBOUNCE consecutive ticks before scanning resumes.
            if (row_s_q == 4'hF) begin
              if (rcnt_q == DEBOUNCE - 4'd1) begin
                state_q <= StScan;
                cidx_q  <= cidx_q + 2'd1;
              end else begin
                rcnt_q <= rcnt_q + 4'd1;
              end
            end else begin
              rcnt_q <= '0;
            end
`ifdef KEYPAD_REPEAT_EN
            if (row_s_q == rsave_q) pcnt_q <= accept ? 10'd0 : pcnt_q + 10'd1;
            else                    pcnt_q <= '0;
`endif
          end
          default: state_q <= StScan;
        endcase
      end

      if (accept) begin
        key_valid_q <= 1'b1;
        key_code_q  <= code;
      end

      if (clr)         d_q <= '0;
      else if (accept) d_q <= {d_q[27:0], code};
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: keypad matrix model, scoreboard of expected accepts.
`timescale 1ns/1ps

module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [31:0] d;
  logic [3:0]  key_code;
  logic        key_valid;

  logic        key_on;
  logic [1:0]  key_r, key_c;
  logic [31:0] exp_d;
  logic        prev_kv = 1'b0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  keypad_scan #(
    .SCAN_DIV    (16'd4),
    .DEBOUNCE    (4'd3),
    .REPEAT_TICKS(10'd8)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .row      (row),
    .clr      (clr),
    .col      (col),
    .d        (d),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: the held key pulls its row low only while its column is driven.
  always_comb begin
    row = 4'hF;
    if (key_on && !col[key_c]) row[key_r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && key_valid) begin
      exp_t e;
      check("kv_width", {31'd0, prev_kv}, 32'd0);
      check("kv_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
        check("d_on_accept", d, e.d);
      end
    end
    prev_kv = key_valid;
  end

  task automatic wait_col(input logic [3:0] target);
    for (int i = 0; i < 64 && col == target; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 64 && col != target; i++) begin
      @(posedge clk); #1;
    end
    check("col_reach", {28'd0, col}, {28'd0, target});
  endtask

  task automatic wait_sb(input int target, input string tag);
    for (int i = 0; i < 600 && sb.size() > target; i++) begin
      @(posedge clk); #1;
    end
    check(tag, sb.size(), target);
  endtask

  task automatic push(input logic [3:0] c);
    exp_d = clr ? 32'h0 : {exp_d[27:0], c};
    sb.push_back('{code: c, d: exp_d});
  endtask

  task automatic hold_key(input logic [1:0] r, input logic [1:0] c);
    wait_col(~(4'b0001 << c));
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  task automatic release_key();
    key_on = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int extra);
    hold_key(r, c);
    push({r, c});
    wait_sb(0, "accept_seen");
    repeat (extra) @(posedge clk);
    #1;
    release_key();
  endtask

  initial begin
    int cnt;
    rstn   = 1'b0;
    clr    = 1'b0;
    key_on = 1'b0;
    key_r  = '0;
    key_c  = '0;
    exp_d  = '0;
    #1;
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_d", d, 32'h0);
    check("rst_kv", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle scan: first step after 4 clk, then every 4 clk.
    cnt = 0;
    for (int i = 0; i < 20 && col == 4'b1110; i++) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("first_step_clks", cnt, 4);
    check("col_step1", {28'd0, col}, 32'hD);
    repeat (2) @(posedge clk);
    #1;
    check("col_hold_mid", {28'd0, col}, 32'hD);
    repeat (2) @(posedge clk);
    #1;
    check("col_step2", {28'd0, col}, 32'hB);
    repeat (4) @(posedge clk);
    #1;
    check("col_step3", {28'd0, col}, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    check("col_wrap", {28'd0, col}, 32'hE);

    // Key 6 held about 10 ticks, then key F.
    press(2'd1, 2'd2, 24);
    check("d_after_6", d, 32'h00000006);
    press(2'd3, 2'd3, 4);
    check("d_after_6F", d, 32'h0000006F);

    // Bounce: contact seen on a single tick only.
    hold_key(2'd0, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    release_key();
    check("bounce_d", d, exp_d);
    check("bounce_sb", sb.size(), 0);

    // Nine presses of 1..9 push the oldest nibbles out.
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] kc;
      kc = k[3:0];
      press(kc[3:2], kc[1:0], 2);
    end
    check("d_nine", d, 32'h23456789);

    // clr held across an accept: d clears, key_code still updates.
    clr = 1'b1;
    press(2'd2, 2'd1, 2);
    clr = 1'b0;
    check("clr_d", d, 32'h0);
    check("clr_code", {28'd0, key_code}, 32'h9);
    exp_d = 32'h0;

    // Key A held 30 ticks after accept.
    hold_key(2'd2, 2'd2);
    push(4'hA);
`ifdef KEYPAD_REPEAT_EN
    push(4'hA);
    push(4'hA);
    push(4'hA);
    wait_sb(3, "repeat_first");
`else
    wait_sb(0, "repeat_first");
`endif
    repeat (120) @(posedge clk);
    #1;
    release_key();
    check("repeat_sb", sb.size(), 0);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_d", d, 32'h0000AAAA);
`else
    check("repeat_d", d, 32'h0000000A);
`endif

    // Reset while PRESSED; key stays held and is accepted again afterwards.
    hold_key(2'd1, 2'd2);
    push(4'h6);
    wait_sb(0, "pre_reset_accept");
    repeat (8) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_d", d, 32'h0);
    check("midrst_col", {28'd0, col}, 32'hE);
    check("midrst_kv", {31'd0, key_valid}, 32'd0);
    check("midrst_code", {28'd0, key_code}, 32'd0);
    exp_d = 32'h0;
    push(4'h6);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_sb(0, "post_reset_accept");
    release_key();
    check("final_d", d, 32'h00000006);
    check("final_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
